// File: rtl/clk_cen_gen.sv
// Fractional clock-enable generator: NUM_CH accumulator-based num/den enables on one clock,
// with core reset held until the synchronised PLL lock has been stable for LOCK_CYCLES cycles.
module clk_cen_gen #(
  parameter int NUM_CH      = 3,
  parameter int ACC_W       = 16,
  parameter int LOCK_CYCLES = 1024,
  parameter int LOCK_W      = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pll_locked,
  input  logic [NUM_CH*ACC_W-1:0] cfg_num,
  input  logic [NUM_CH*ACC_W-1:0] cfg_den,
  input  logic                    cfg_load,
  output logic [NUM_CH-1:0]       cen,
  output logic                    sys_rst,
  output logic                    ready,
  output logic [NUM_CH-1:0]       cfg_err
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam logic [LOCK_W-1:0] CNT_LAST = LOCK_W'(LOCK_CYCLES - 1);

  state_t            state, state_nxt;
  logic              lock_meta, lock_sync;
  logic [LOCK_W-1:0] lock_cnt, lock_cnt_nxt;
  logic              run_go;

  // Handshake: cfg_load is a one-cycle strobe with no back-pressure; it is always accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
      state     <= WAIT_LOCK;
      lock_cnt  <= '0;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_sync <= lock_meta;
      state     <= state_nxt;
      lock_cnt  <= lock_cnt_nxt;
      sys_rst   <= (state_nxt != RUN);
      ready     <= (state_nxt == RUN);
    end
  end

  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    case (state)
      WAIT_LOCK: begin
        lock_cnt_nxt = '0;
        if (lock_sync) state_nxt = STABLE;
      end
      STABLE: begin
        if (!lock_sync) begin
          state_nxt    = WAIT_LOCK;
          lock_cnt_nxt = '0;
        end else if (lock_cnt == CNT_LAST) begin
          state_nxt    = RUN;
          lock_cnt_nxt = '0;
        end else begin
          lock_cnt_nxt = lock_cnt + LOCK_W'(1);
        end
      end
      RUN: begin
        lock_cnt_nxt = '0;
        if (!lock_sync) state_nxt = WAIT_LOCK;
      end
      default: begin
        state_nxt    = WAIT_LOCK;
        lock_cnt_nxt = '0;
      end
    endcase
  end

  // Channels only advance on edges where RUN is both the current and the next state.
  assign run_go = (state == RUN) && lock_sync;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ACC_W-1:0] num_r, den_r, acc;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] in_num, in_den;
    logic             new_err, ch_on, cen_q, err_q;

    assign in_num  = cfg_num[i*ACC_W +: ACC_W];
    assign in_den  = cfg_den[i*ACC_W +: ACC_W];
    assign new_err = (in_num != '0) && ((in_den == '0) || (in_num > in_den));
    assign ch_on   = run_go && (num_r != '0) && !err_q;
    assign sum     = {1'b0, acc} + {1'b0, num_r};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        num_r <= '0;
        den_r <= '0;
        acc   <= '0;
        cen_q <= 1'b0;
        err_q <= 1'b0;
      end else if (cfg_load) begin
        num_r <= in_num;
        den_r <= in_den;
        err_q <= new_err;
        acc   <= '0;
        cen_q <= 1'b0;
      end else if (!ch_on) begin
        acc   <= '0;
        cen_q <= 1'b0;
      end else if (sum >= {1'b0, den_r}) begin
        // Remainder carries into the next period, so the long-run rate is exact.
        acc   <= ACC_W'(sum - {1'b0, den_r});
        cen_q <= 1'b1;
      end else begin
        acc   <= sum[ACC_W-1:0];
        cen_q <= 1'b0;
      end
    end

    assign cen[i]     = cen_q;
    assign cfg_err[i] = err_q;
  end

endmodule

// File: tb/tb_clk_cen_gen.sv
// Bench for clk_cen_gen: lock sequencing, ratio patterns, illegal config, realignment and reset.
module tb_clk_cen_gen;

  localparam int NUM_CH = 3;
  localparam int ACC_W  = 16;
  localparam int LC     = 16;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    pll_locked;
  logic [NUM_CH*ACC_W-1:0] cfg_num, cfg_den;
  logic                    cfg_load;
  logic [NUM_CH-1:0]       cen, cfg_err;
  logic                    sys_rst, ready;

  int n_pass  = 0;
  int n_total = 0;
  int m_num[NUM_CH];
  int m_den[NUM_CH];
  int n_edge;

  clk_cen_gen #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_CYCLES(LC), .LOCK_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .cfg_num(cfg_num),
    .cfg_den(cfg_den), .cfg_load(cfg_load), .cen(cen), .sys_rst(sys_rst),
    .ready(ready), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Reference: after alignment, channel pulses on edge n iff floor(n*num/den) steps up.
  function automatic logic [NUM_CH-1:0] model_cen(input int n);
    logic [NUM_CH-1:0] r;
    longint a, b;
    r = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (n >= 1 && m_num[c] != 0 && m_den[c] != 0 && m_num[c] <= m_den[c]) begin
        a = (longint'(n) * m_num[c]) / m_den[c];
        b = (longint'(n - 1) * m_num[c]) / m_den[c];
        r[c] = (a != b);
      end
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cfg(input int n0, d0, n1, d1, n2, d2);
    cfg_num = {ACC_W'(n2), ACC_W'(n1), ACC_W'(n0)};
    cfg_den = {ACC_W'(d2), ACC_W'(d1), ACC_W'(d0)};
    m_num[0] = n0; m_den[0] = d0;
    m_num[1] = n1; m_den[1] = d1;
    m_num[2] = n2; m_den[2] = d2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_locked = 1'b0; cfg_load = 1'b0;
    drive_cfg(0, 0, 0, 0, 0, 0);
    step(); step();
    n_total++;
    if ({cen, sys_rst, ready, cfg_err} !== {3'b000, 1'b1, 1'b0, 3'b000})
      $display("FAIL reset_values got=%b exp=%b", {cen, sys_rst, ready, cfg_err}, 8'b000_1_0_000);
    else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_lock_glitch();
    pll_locked = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 13) pll_locked = 1'b0;
      n_total++;
      if ({ready, sys_rst} !== 2'b01) $display("FAIL glitch_pre k=%0d got=%b exp=01", k, {ready, sys_rst});
      else n_pass++;
    end
    pll_locked = 1'b1;
    for (int k = 1; k <= LC + 3; k++) begin
      step();
      n_total++;
      if (k < LC + 3 && {ready, sys_rst} !== 2'b01)
        $display("FAIL glitch_hold k=%0d got=%b exp=01", k, {ready, sys_rst});
      else if (k == LC + 3 && {ready, sys_rst} !== 2'b10)
        $display("FAIL glitch_release k=%0d got=%b exp=10", k, {ready, sys_rst});
      else n_pass++;
    end
  endtask

  task automatic test_lock_seq();
    rst_n = 1'b0; pll_locked = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    drive_cfg(1, 1, 1, 2, 1, 8);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    n_total++;
    if ({cen, cfg_err} !== 6'b0) $display("FAIL preload got=%b exp=000000", {cen, cfg_err});
    else n_pass++;
    pll_locked = 1'b1;
    for (int k = 1; k <= LC + 3; k++) begin
      step();
      n_total++;
      if (k < LC + 3 && {ready, sys_rst, cen} !== 5'b01_000)
        $display("FAIL lock_hold k=%0d got=%b exp=01000", k, {ready, sys_rst, cen});
      else if (k == LC + 3 && {ready, sys_rst, cen} !== 5'b10_000)
        $display("FAIL lock_release k=%0d got=%b exp=10000", k, {ready, sys_rst, cen});
      else n_pass++;
    end
    n_edge = 0;
  endtask

  task automatic test_ratios();
    int cnt[NUM_CH];
    logic [NUM_CH-1:0] exp;
    int exp_cnt[NUM_CH];
    exp_cnt[0] = 800; exp_cnt[1] = 400; exp_cnt[2] = 100;
    for (int c = 0; c < NUM_CH; c++) cnt[c] = 0;
    for (int k = 0; k < 800; k++) begin
      step();
      n_edge++;
      exp = model_cen(n_edge);
      for (int c = 0; c < NUM_CH; c++) cnt[c] += int'(cen[c]);
      n_total++;
      if (cen !== exp) $display("FAIL ratio_cen n=%0d got=%b exp=%b", n_edge, cen, exp);
      else n_pass++;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      n_total++;
      if (cnt[c] != exp_cnt[c]) $display("FAIL ratio_count ch=%0d got=%0d exp=%0d", c, cnt[c], exp_cnt[c]);
      else n_pass++;
    end
  endtask

  task automatic test_fractional();
    logic [15:0] first16;
    logic [NUM_CH-1:0] exp;
    int cnt0, cnt1;
    cnt0 = 0; cnt1 = 0; first16 = '0;
    drive_cfg(3, 8, 1, 4, 0, 5);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    n_edge = 0;
    n_total++;
    if (cen !== 3'b000) $display("FAIL frac_load_edge got=%b exp=000", cen);
    else n_pass++;
    for (int k = 0; k < 800; k++) begin
      step();
      n_edge++;
      exp = model_cen(n_edge);
      if (n_edge <= 16) first16[n_edge-1] = cen[0];
      cnt0 += int'(cen[0]);
      cnt1 += int'(cen[1]);
      n_total++;
      if (cen !== exp) $display("FAIL frac_cen n=%0d got=%b exp=%b", n_edge, cen, exp);
      else n_pass++;
    end
    n_total++;
    if (first16 !== 16'hA4A4) $display("FAIL frac_pattern got=%h exp=a4a4", first16);
    else n_pass++;
    n_total++;
    if (cnt0 != 300 || cnt1 != 200) $display("FAIL frac_count got=%0d/%0d exp=300/200", cnt0, cnt1);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [NUM_CH-1:0] exp;
    int d[NUM_CH];
    int nm[NUM_CH];
    int len;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        d[c]  = int'($urandom_range(40, 1));
        nm[c] = int'($urandom_range(d[c], 0));
      end
      drive_cfg(nm[0], d[0], nm[1], d[1], nm[2], d[2]);
      cfg_load = 1'b1;
      step();
      cfg_load = 1'b0;
      n_edge = 0;
      n_total++;
      if ({cen, cfg_err} !== 6'b0) $display("FAIL rand_load r=%0d got=%b exp=000000", r, {cen, cfg_err});
      else n_pass++;
      len = int'($urandom_range(120, 40));
      for (int k = 0; k < len; k++) begin
        step();
        n_edge++;
        exp = model_cen(n_edge);
        n_total++;
        if (cen !== exp) $display("FAIL rand_cen r=%0d n=%0d got=%b exp=%b", r, n_edge, cen, exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_illegal();
    logic [NUM_CH-1:0] exp;
    drive_cfg(1, 2, 5, 4, 1, 0);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    n_edge = 0;
    n_total++;
    if (cfg_err !== 3'b110) $display("FAIL illegal_err got=%b exp=110", cfg_err);
    else n_pass++;
    for (int k = 0; k < 24; k++) begin
      step();
      n_edge++;
      exp = model_cen(n_edge);
      n_total++;
      if (cen !== exp) $display("FAIL illegal_cen n=%0d got=%b exp=%b", n_edge, cen, exp);
      else n_pass++;
    end
    drive_cfg(2, 3, 1, 5, 4, 4);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    n_edge = 0;
    n_total++;
    if (cfg_err !== 3'b000) $display("FAIL illegal_clear got=%b exp=000", cfg_err);
    else n_pass++;
    for (int k = 0; k < 20; k++) begin
      step();
      n_edge++;
      exp = model_cen(n_edge);
      n_total++;
      if (cen !== exp) $display("FAIL reload_cen n=%0d got=%b exp=%b", n_edge, cen, exp);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [NUM_CH-1:0] exp;
    drive_cfg(1, 1, 1, 1, 1, 1);
    cfg_load = 1'b1;
    step();
    n_total++;
    if (cen !== 3'b000) $display("FAIL b2b_first got=%b exp=000", cen);
    else n_pass++;
    drive_cfg(2, 5, 1, 3, 1, 1);
    step();
    cfg_load = 1'b0;
    n_edge = 0;
    n_total++;
    if (cen !== 3'b000) $display("FAIL b2b_second got=%b exp=000", cen);
    else n_pass++;
    for (int k = 0; k < 30; k++) begin
      step();
      n_edge++;
      exp = model_cen(n_edge);
      n_total++;
      if (cen !== exp) $display("FAIL b2b_cen n=%0d got=%b exp=%b", n_edge, cen, exp);
      else n_pass++;
    end
  endtask

  task automatic test_realign_lockloss();
    logic [NUM_CH-1:0] exp;
    drive_cfg(1, 3, 1, 3, 1, 3);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    n_edge = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      n_edge++;
      exp = (n_edge % 3 == 0) ? 3'b111 : 3'b000;
      n_total++;
      if (cen !== exp) $display("FAIL realign_cen n=%0d got=%b exp=%b", n_edge, cen, exp);
      else n_pass++;
    end
    pll_locked = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      step();
      n_edge++;
      exp = model_cen(n_edge);
      n_total++;
      if ({ready, sys_rst, cen} !== {2'b10, exp})
        $display("FAIL lockloss_sync k=%0d got=%b exp=%b", k, {ready, sys_rst, cen}, {2'b10, exp});
      else n_pass++;
    end
    drive_cfg(1, 1, 2, 2, 3, 2);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    n_total++;
    if ({ready, sys_rst, cen, cfg_err} !== 8'b01_000_100)
      $display("FAIL lockloss_edge got=%b exp=01000100", {ready, sys_rst, cen, cfg_err});
    else n_pass++;
    pll_locked = 1'b1;
    for (int k = 1; k <= LC + 3; k++) begin
      step();
      n_total++;
      if (k < LC + 3 && {ready, sys_rst, cen} !== 5'b01_000)
        $display("FAIL relock_hold k=%0d got=%b exp=01000", k, {ready, sys_rst, cen});
      else if (k == LC + 3 && {ready, sys_rst} !== 2'b10)
        $display("FAIL relock_release k=%0d got=%b exp=10", k, {ready, sys_rst});
      else n_pass++;
    end
    n_edge = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      n_edge++;
      exp = model_cen(n_edge);
      n_total++;
      if (cen !== exp) $display("FAIL latched_cfg_cen n=%0d got=%b exp=%b", n_edge, cen, exp);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({cen, sys_rst, ready, cfg_err} !== 8'b000_1_0_000)
      $display("FAIL async_reset got=%b exp=00010000", {cen, sys_rst, ready, cfg_err});
    else n_pass++;
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= LC + 3; k++) begin
      step();
      n_total++;
      if (k < LC + 3 && {ready, sys_rst} !== 2'b01)
        $display("FAIL post_reset_hold k=%0d got=%b exp=01", k, {ready, sys_rst});
      else if (k == LC + 3 && {ready, sys_rst} !== 2'b10)
        $display("FAIL post_reset_release k=%0d got=%b exp=10", k, {ready, sys_rst});
      else n_pass++;
    end
    for (int k = 0; k < 10; k++) begin
      step();
      n_total++;
      if ({cen, cfg_err} !== 6'b0) $display("FAIL cleared_cfg k=%0d got=%b exp=000000", k, {cen, cfg_err});
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_lock_glitch();
    test_lock_seq();
    test_ratios();
    test_fractional();
    test_random();
    test_illegal();
    test_back_to_back();
    test_realign_lockloss();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/clk_cen_gen.md
# clk_cen_gen

Parametrised fractional clock-enable generator with PLL-lock reset sequencing. It runs on the single system clock taken from the PLL and produces NUM_CH independent single-cycle clock enables at runtime-programmable ratios num/den (e.g. 6 MHz and 24 MHz from 48 MHz). It also holds the core in reset until the PLL lock has been stable for a programmable time. It sits between the PLL wrapper and the core, and replaces fixed PLL output taps with enables on one clock domain.

## Interface
- NUM_CH, 3: number of enable channels (1..8)
- ACC_W, 16: width of each channel's num/den/accumulator
- LOCK_CYCLES, 1024: cycles of continuous synchronised lock required before release (>=1)
- LOCK_W, 11: counter width; must satisfy 2^LOCK_W > LOCK_CYCLES

- clk  in  1  system clock (PLL output)
- rst_n  in  1  asynchronous active-low reset
- pll_locked  in  1  PLL lock, asynchronous; synchronised internally by a 2-FF chain
- cfg_num  in  NUM_CH*ACC_W  per-channel numerator, channel i at [i*ACC_W +: ACC_W]
- cfg_den  in  NUM_CH*ACC_W  per-channel denominator, same packing
- cfg_load  in  1  single-cycle strobe: latch cfg_num/cfg_den and phase-realign all channels
- cen  out  NUM_CH  per-channel clock enable, registered
- sys_rst  out  1  synchronous active-high reset to the core, registered
- ready  out  1  high while in RUN
- cfg_err  out  NUM_CH  per-channel illegal-config flag, registered

## Operation
- Reset (rst_n=0, async): FSM=WAIT_LOCK, sync FFs=0, lock counter=0, num/den regs=0, accumulators=0, cen=0, sys_rst=1, ready=0, cfg_err=0.
- FSM states:
  - WAIT_LOCK: go to STABLE when synchronised lock=1, with counter=0.
  - STABLE: counter increments each cycle while lock=1. When counter reaches LOCK_CYCLES-1, go to RUN. Lock=0 returns the FSM to WAIT_LOCK.
  - RUN: sys_rst=0, ready=1. Lock=0 returns the FSM to WAIT_LOCK.
- Outside RUN: cen=0, sys_rst=1, ready=0, and accumulators are held at 0. Config regs and cfg_err keep their values.
- Lock loss in RUN: the next edge after the synchronised lock falls sets cen=0, sys_rst=1, ready=0 and clears the accumulators.
- cfg_load is accepted in any state. On the next edge:
  - the num/den regs take the inputs;
  - cfg_err[i] is recomputed from the new values;
  - all accumulators go to 0 and all cen go to 0, which phase-aligns every channel.
- Channel i in RUN, when not being loaded and with legal config:
  - sum = acc + num, computed at ACC_W+1 bits, so no overflow.
  - If sum >= den: cen[i] <= 1 and acc <= sum - den.
  - Otherwise: cen[i] <= 0 and acc <= sum.
- Channel rules:
  - num=0: channel off, cen[i]=0, cfg_err[i]=0.
  - num>den or den=0 (with num != 0): illegal. cfg_err[i]=1, cen[i]=0, acc held at 0.
  - num=den: cen[i]=1 every RUN cycle.
- Long-run cen rate is exactly num/den of clk. Spacing between pulses is floor or ceil of den/num cycles; the remainder is never lost.

## Timing
- pll_locked to synchronised lock: 2 cycles.
- Release: sys_rst falls and ready rises on the edge that enters RUN. That is LOCK_CYCLES cycles after entering STABLE, and LOCK_CYCLES+3 edges after pll_locked rises (2 sync + 1 WAIT_LOCK→STABLE + LOCK_CYCLES).
- First cen: take edge 1 as the first edge with the FSM in RUN, or the first edge after a cfg_load edge. cen[i] first goes high after edge ceil(den/num).
  - num=1, den=4: cen high after edges 4, 8, 12, …
  - num=3, den=8: cen high after edges 3, 6, 8, 11, 14, 16, … (pattern repeats every 8).
- cfg_load in the same cycle as lock loss: the config is latched, and the FSM goes to WAIT_LOCK.
- cfg_load on consecutive cycles: each load restarts alignment, and the last load wins.
- cen is held 0 on the cfg_load edge even for num=den; it goes high from the next edge.

## Test plan
- Lock sequencing: LOCK_CYCLES=16, pll_locked rises at edge 10 → sys_rst=1/ready=0 through edge 28, sys_rst=0/ready=1 after edge 29.
- Lock glitch: drop pll_locked for 1 cycle during STABLE at count 10 → counter restarts, and release is delayed by the full 16 cycles after relock.
- Ratios: 48 MHz model, channels (1/1, 1/2, 1/8) loaded before lock → in RUN, cen[0] every cycle, cen[1] after even edges, cen[2] after edges 8, 16, …; over 800 cycles the counts are exactly 800/400/100.
- Fractional: num=3, den=8 → pulses after edges 3, 6, 8, 11, 14, 16; exactly 300 pulses in 800 cycles.
- Illegal config: ch1 num=5, den=4 and ch2 num=1, den=0 → cfg_err=3'b110, cen[2:1]=0, ch0 unaffected. Reload with legal values → cfg_err clears one edge after cfg_load.
- Realign and lock loss: cfg_load mid-run with num=1, den=3 on all channels → all cen fire together after edges 3, 6, …. Then pll_locked low → cen=0 and sys_rst=1 within 3 edges, and ready=0. Assert rst_n low mid-run → all outputs go to their reset values immediately (asynchronously).
